// File: rtl/alu_result_stage.sv
// alu_result_stage: 2-entry result buffer feeding ZHi/ZLo/Hi/Lo and zero flag.
// Optional commit counter on perf_cnt enabled by `define ALU_RESULT_PERF_EN.
module alu_result_stage #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                res_valid,
  output logic                res_ready,
  input  logic [OP_W-1:0]     res_op,
  input  logic [2*DATA_W-1:0] res_z,
  input  logic [DATA_W-1:0]   res_hi,
  input  logic [DATA_W-1:0]   res_lo,
  input  logic                commit_en,
  input  logic [1:0]          rd_sel,
  output logic [DATA_W-1:0]   rd_data,
  output logic                zero_flag,
  output logic [1:0]          occ,
  output logic                err_op,
  output logic [15:0]         perf_cnt
);

  typedef struct packed {
    logic [OP_W-1:0]     op;
    logic [2*DATA_W-1:0] z;
    logic [DATA_W-1:0]   hi;
    logic [DATA_W-1:0]   lo;
  } ent_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } st_e;

  st_e  state_q, state_d;
  ent_t ent0_q, ent0_d;
  ent_t ent1_q, ent1_d;
  ent_t new_ent;

  logic [DATA_W-1:0] zhi_q, zhi_d;
  logic [DATA_W-1:0] zlo_q, zlo_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic              zero_q, zero_d;
  logic              err_q, err_d;

  logic push;
  logic pop;
  logic is_z;
  logic is_md;

  // Ready depends on occupancy and clear only, never on commit_en.
  assign res_ready = !clear && (state_q != S_FULL);
  assign push      = res_valid && res_ready;
  assign pop       = commit_en && (state_q != S_EMPTY);
  assign occ       = state_q;

  assign new_ent.op = res_op;
  assign new_ent.z  = res_z;
  assign new_ent.hi = res_hi;
  assign new_ent.lo = res_lo;

  assign is_z  = (ent0_q.op <= OP_W'(4));
  assign is_md = (ent0_q.op == OP_W'(5)) ||
                 (ent0_q.op == OP_W'(6));

  // Buffer next state: head lives in ent0, second entry in ent1.
  always_comb begin
    state_d = state_q;
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    unique case (state_q)
      S_EMPTY: begin
        if (push) begin
          ent0_d  = new_ent;
          state_d = S_ONE;
        end
      end
      S_ONE: begin
        if (push && pop) begin
          ent0_d = new_ent;
        end else if (push) begin
          ent1_d  = new_ent;
          state_d = S_FULL;
        end else if (pop) begin
          state_d = S_EMPTY;
        end
      end
      S_FULL: begin
        if (pop) begin
          ent0_d  = ent1_q;
          state_d = S_ONE;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // Commit of the buffer head into the architectural registers.
  always_comb begin
    zhi_d  = zhi_q;
    zlo_d  = zlo_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    zero_d = zero_q;
    err_d  = err_q;
    if (pop) begin
      unique case (1'b1)
        is_z: begin
          zlo_d  = ent0_q.z[DATA_W-1:0];
          zhi_d  = ent0_q.z[2*DATA_W-1:DATA_W];
          zero_d = (ent0_q.z == '0);
        end
        is_md: begin
          hi_d   = ent0_q.hi;
          lo_d   = ent0_q.lo;
          zero_d = ({ent0_q.hi, ent0_q.lo} == '0);
        end
        default: err_d = 1'b1;
      endcase
    end
  end

  // State registers; clear discards any push or commit in its cycle.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= S_EMPTY;
      ent0_q  <= '0;
      ent1_q  <= '0;
      zhi_q   <= '0;
      zlo_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
      zhi_q   <= zhi_d;
      zlo_q   <= zlo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
    end
  end

  assign zero_flag = zero_q;
  assign err_op    = err_q;

  // Read port mux over the architectural registers.
  always_comb begin
    rd_data = '0;
    unique case (rd_sel)
      2'b00:   rd_data = zlo_q;
      2'b01:   rd_data = zhi_q;
      2'b10:   rd_data = hi_q;
      2'b11:   rd_data = lo_q;
      default: rd_data = '0;
    endcase
  end

`ifdef ALU_RESULT_PERF_EN
  logic [15:0] perf_q, perf_d;

  // Saturating count of commits, undefined opcodes included.
  always_comb begin
    perf_d = perf_q;
    if (pop && (perf_q != 16'hFFFF)) begin
      perf_d = perf_q + 16'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clock) begin
    if (clear) begin
      perf_q <= 16'h0000;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_cnt = perf_q;
`else
  assign perf_cnt = 16'h0000;
`endif

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Downstream neighbour of the ALU: accepts each ALU result through a valid/ready handshake into a 2-entry buffer.
- Commits buffered results, one per enabled cycle, into the architectural ZHi/ZLo, Hi and Lo registers, and updates a registered zero flag.
- Drives the selected register onto the datapath bus read port.
- Decouples ALU result timing from control-unit register-write timing.

Parameters:
- DATA_W, 32, width of each result half and of every architectural register.
- OP_W, 4, width of the ALU operation code carried with each result.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- clear  in  1  synchronous active-high reset.
- res_valid  in  1  ALU result present this cycle.
- res_ready  out  1  stage can accept a result this cycle.
- res_op  in  OP_W  opcode of the result (0000–0100 Z-class, 0101 MUL, 0110 DIV).
- res_z  in  2*DATA_W  64-bit Z result.
- res_hi  in  DATA_W  MUL high word / DIV remainder.
- res_lo  in  DATA_W  MUL low word / DIV quotient.
- commit_en  in  1  control unit permits commit of buffer head this cycle.
- rd_sel  in  2  read select: 00 ZLo, 01 ZHi, 10 Hi, 11 Lo.
- rd_data  out  DATA_W  combinational mux of the selected architectural register.
- zero_flag  out  1  registered zero flag of the last committed valid result.
- occ  out  2  buffer occupancy, 0–2.
- err_op  out  1  sticky flag: an undefined opcode was committed.
- perf_cnt  out  16  committed-result counter (see Optional Feature).

Behaviour:
- Reset:
  - clear high at a rising edge sets the buffer empty (occ=0).
  - zhi, zlo, hi, lo = 0; zero_flag=0; err_op=0; perf_cnt=0.
  - res_ready is 0 in any cycle where clear is high.
  - A push or commit in the clear cycle is discarded.
  - Clear mid-stream flushes buffered entries without committing them.
- Buffer states:
  - EMPTY (occ=0), ONE (occ=1), FULL (occ=2). Entries are {op, z, hi, lo}, FIFO order.
- res_ready:
  - res_ready = !clear && (occ != 2).
  - It depends on current occupancy only, never on commit_en. No combinational path from commit_en to res_ready.
- Push: res_valid && res_ready at an edge appends the entry.
- Pop: commit_en && occ != 0 at an edge removes the head and commits it at that same edge.
- Transitions:
  - EMPTY: push -> ONE.
  - ONE: push only -> FULL; pop only -> EMPTY; push and pop -> ONE (new entry becomes head).
  - FULL: pop -> ONE. No push is possible in FULL, even when a pop occurs in the same cycle.
- Latency: no bypass. An entry accepted at edge N commits at edge N+1 at the earliest. Register values are visible on rd_data after that edge.
- Commit effect by opcode:
  - 0000–0100: zlo <= z[31:0], zhi <= z[63:32]; zero_flag <= (z == 0), compared over all 64 bits. Hi and Lo are unchanged.
  - 0101 and 0110: hi <= res_hi, lo <= res_lo; zero_flag <= ({hi,lo} == 0). ZHi and ZLo are unchanged.
  - 0111–1111: no register or zero_flag change; err_op <= 1, sticky until clear.
- commit_en with occ=0: no effect, no error.
- res_valid held high while res_ready=0: upstream must hold its data stable; no entry is lost or duplicated.
- rd_data reflects register state after the last edge; a commit is visible in the following cycle.

Optional Feature:
- Macro: ALU_RESULT_PERF_EN.
- Defined:
  - perf_cnt increments by 1 on every commit, including undefined opcodes.
  - Saturates at 16'hFFFF.
  - Reset to 0 by clear.
- Undefined: perf_cnt is tied to 16'h0000 and no counter flops exist. The port is present either way.

Test Plan:
- Reset then idle -> rd_data=0 for all four rd_sel values, zero_flag=0, occ=0, res_ready=1.
- Push op 0011, z=64'h0000_0000_0000_0005, commit_en=1 from that same cycle -> no commit at the push edge; at the next edge rd_sel=00 gives 32'h5, zero_flag=0, occ=0.
- Push MUL: res_hi=32'h1, res_lo=32'hFFFF_FFFE. Then push op 0100 with z=0 while commit_en=0 -> occ=2 and res_ready=0. Raise commit_en for two cycles -> Hi=1, Lo=FFFF_FFFE, ZLo=0, ZHi=0, zero_flag=1.
- FULL with res_valid held and commit_en=1 -> one entry popped, no push in that cycle, push accepted the following cycle. Total entries committed = total accepted, in FIFO order.
- Commit op 1010 -> all registers unchanged, err_op=1 and stays 1 across further valid commits until clear.
- Two entries buffered, assert clear for one cycle -> occ=0, all registers 0, perf_cnt=0. The flushed entries never appear on rd_data.
